// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential multiplier front-end and datapath.
package mult_pkg;

  localparam int XLEN_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Operand FIFO: power-of-two depth, head visible combinationally so a pop can
// load the operand registers on the same edge.
module mult_op_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign pop_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage needs no reset: contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mult_issue_queue.sv
// Buffers operand pairs, issues them one at a time to the sequential multiplier
// and hands each captured product downstream over valid/ready.
module mult_issue_queue
  import mult_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_a,
  input  logic [XLEN-1:0]            in_b,
  output logic                       mul_start,
  output logic [XLEN-1:0]            mul_a,
  output logic [XLEN-1:0]            mul_b,
  input  logic                       mul_done,
  input  logic [2*XLEN-1:0]          mul_product,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*XLEN-1:0]          out_product,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  issue_state_t      r_state;
  issue_state_t      w_state_next;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_product;
  logic [2*XLEN-1:0] w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;

  mult_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data ({in_a, in_b}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // in_ready comes from the registered count only, so a same-cycle pop never frees a slot.
  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full;
  assign w_pop    = ~w_empty & ((r_state == IDLE) | ((r_state == HOLD) & out_ready));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_next = ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (mul_done) w_state_next = HOLD;
      HOLD:    if (out_ready) w_state_next = w_empty ? IDLE : ISSUE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) {r_a, r_b} <= w_head;
      if ((r_state == WAIT) && mul_done) r_product <= mul_product;
    end
  end

  assign mul_start   = (r_state == ISSUE);
  assign mul_a       = r_a;
  assign mul_b       = r_b;
  assign out_valid   = (r_state == HOLD);
  assign out_product = r_product;
  assign busy        = (r_state != IDLE);

endmodule
